prog_loader_ctrl: RTL and testbench
===================================

PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 SHALL have a single clock domain and a synchronous, active-high reset; no other clocks or async resets.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port host_valid, input, 1 bit: host write request.
REQ-005 SHALL have port host_ready, output, 1 bit: write accepted this cycle when host_valid is also 1.
REQ-006 SHALL have port host_addr, input, 4 bits: program-memory write address.
REQ-007 SHALL have port host_data, input, 8 bits: instruction byte to write.
REQ-008 SHALL have port run_req, input, 1 bit: single-cycle pulse that starts the CPU.
REQ-009 SHALL have port load_req, input, 1 bit: single-cycle pulse that stops the CPU and enters load mode.
REQ-010 SHALL have port cpu_addr, input, 4 bits: CPU instruction pointer.
REQ-011 SHALL have port cpu_data, output, 8 bits: instruction byte to the CPU.
REQ-012 SHALL have port cpu_n_reset, output, 1 bit: active-low CPU reset.
REQ-013 SHALL have port state, output, 2 bits: current controller state encoding.
REQ-014 SHALL have port wr_count, output, 5 bits: number of writes accepted since the last entry into LOAD, saturating at 16.
REQ-015 SHALL have port checksum, output, 8 bits: sum mod 256 of the bytes accepted since the last entry into LOAD.

Function
REQ-016 SHALL implement the states LOAD=2'b00, CRST=2'b01 and RUN=2'b10; the encoding 2'b11 is unreachable and SHALL recover to LOAD on the next cycle.
REQ-017 In LOAD: host_ready=1, cpu_n_reset=0, cpu_data=8'h00.
REQ-018 In LOAD: host_valid=1 SHALL write host_data into mem[host_addr] at the clock edge, increment wr_count (saturating at 16) and add host_data to checksum.
REQ-019 In LOAD: run_req=1 SHALL move to CRST at the next edge; load_req is ignored.
REQ-020 In LOAD: simultaneous host_valid and run_req SHALL accept the write and also transition.
REQ-021 In CRST: cpu_n_reset=0, host_ready=0, cpu_data=mem[cpu_addr].
REQ-022 CRST SHALL last exactly CRST_CYCLES=2 cycles, counted by a down-counter, then move to RUN.
REQ-023 In CRST: load_req=1 SHALL abort to LOAD at the next edge.
REQ-024 In RUN: cpu_n_reset=1, host_ready=0.
REQ-025 In RUN: cpu_data=mem[cpu_addr] combinationally, so the CPU fetches with zero added latency.
REQ-026 In RUN: load_req=1 SHALL move to LOAD at the next edge; load_req takes priority over a simultaneous run_req, and run_req alone is ignored.
REQ-027 Every entry into LOAD SHALL clear wr_count and checksum in the same edge; memory contents are retained.
REQ-028 host_valid outside LOAD SHALL be stalled (no write, no counter change); the host holds addr and data until host_ready.
REQ-029 A write to the same address more than once SHALL leave the last byte in memory while counting and summing every accepted write.
REQ-030 The first instruction the CPU fetches after CRST SHALL reflect all writes accepted up to and including the edge that left LOAD.

Reset
REQ-031 While reset=1: state=LOAD, all 16 memory words=8'h00, wr_count=0, checksum=0, CRST counter=0, cpu_n_reset=0.
REQ-032 Reset SHALL take priority over every request; reset asserted mid-RUN or mid-CRST SHALL return to LOAD with memory cleared on that edge.

Structure
REQ-033 Package cpu_ctrl_pkg SHALL hold typedef ctrl_state_t (the 2-bit enum above), localparam CRST_CYCLES=2 and localparam IMEM_DEPTH=16.
REQ-034 The memory SHALL be sub-module prog_ram: 16x8 flops, one synchronous write port, one asynchronous read port, synchronous clear on reset.
REQ-035 The FSM, counters and checksum logic SHALL reside in prog_loader_ctrl.

Verification
REQ-036 Reset, then write 8'h31 @0, 8'h0F @1 -> wr_count=2, checksum=8'h40; pulse run_req -> cpu_n_reset stays 0 for exactly 2 cycles, then 1; cpu_addr=1 -> cpu_data=8'h0F.
REQ-037 In LOAD, host_valid and run_req in the same cycle writing 8'hB7 @0 -> write accepted, wr_count=1, and mem[0]=8'hB7 is visible at the first RUN fetch.
REQ-038 In RUN, hold host_valid=1 for 5 cycles -> host_ready=0 throughout and wr_count unchanged; then pulse load_req -> next cycle state=00, host_ready=1, the pending write is accepted, and wr_count goes from 0 to 1.
REQ-039 In LOAD, 20 writes of 8'h10 -> wr_count saturates at 16 and checksum=8'h40 (20 x 16 mod 256).
REQ-040 In RUN, load_req and run_req in the same cycle -> state=LOAD; load_req during CRST -> LOAD without cpu_n_reset ever reaching 1.
REQ-041 In RUN with a nonzero memory image, assert reset for 1 cycle -> state=LOAD, every address reads 8'h00, cpu_n_reset=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the program loader / CPU reset controller.
package cpu_ctrl_pkg;

  localparam int CRST_CYCLES = 2;
  localparam int IMEM_DEPTH  = 16;
  localparam int IMEM_AW     = 4;
  localparam int IMEM_DW     = 8;
  localparam int CNT_W       = 5;
  localparam logic [CNT_W-1:0] WR_COUNT_MAX = 5'd16;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    CRST = 2'b01,
    RUN  = 2'b10
  } ctrl_state_t;

  // Write counter increment that holds once the full memory depth is reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == WR_COUNT_MAX) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// 16x8 flop-based program memory: one synchronous write port, one
// asynchronous read port, synchronous clear on reset.
module prog_ram
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IMEM_AW-1:0] wr_addr,
  input  logic [IMEM_DW-1:0] wr_data,
  input  logic [IMEM_AW-1:0] rd_addr,
  output logic [IMEM_DW-1:0] rd_data
);

  logic [IMEM_DW-1:0] mem [IMEM_DEPTH];

  // Storage update: reset clears every word, otherwise write on wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Zero-latency fetch path for the CPU.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_loader_ctrl.sv
// Program loader: host fills instruction memory while the CPU is held in
// reset, then a short reset window releases the CPU to run from memory.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   LOAD  | CPU held in reset, host writes accepted, counters active
//   CRST  | memory frozen, CPU still in reset for CRST_CYCLES cycles
//   RUN   | CPU released, fetching from memory, host stalled
//   2'b11 | unreachable, falls back to LOAD on the next edge
module prog_loader_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [IMEM_AW-1:0] host_addr,
  input  logic [IMEM_DW-1:0] host_data,
  input  logic               run_req,
  input  logic               load_req,
  input  logic [IMEM_AW-1:0] cpu_addr,
  output logic [IMEM_DW-1:0] cpu_data,
  output logic               cpu_n_reset,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   wr_count,
  output logic [IMEM_DW-1:0] checksum
);

  ctrl_state_t        state_q;
  ctrl_state_t        state_d;
  logic [1:0]         crst_cnt;
  logic               wr_en;
  logic               enter_load;
  logic [IMEM_DW-1:0] ram_rd;

  prog_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (host_addr),
    .wr_data (host_data),
    .rd_addr (cpu_addr),
    .rd_data (ram_rd)
  );

  // Next-state and per-state outputs.
  always_comb begin
    state_d     = state_q;
    host_ready  = 1'b0;
    cpu_n_reset = 1'b0;
    cpu_data    = '0;
    case (state_q)
      LOAD: begin
        host_ready = 1'b1;
        if (run_req) state_d = CRST;
      end
      CRST: begin
        cpu_data = ram_rd;
        if (load_req)            state_d = LOAD;
        else if (crst_cnt == '0) state_d = RUN;
      end
      RUN: begin
        cpu_n_reset = 1'b1;
        cpu_data    = ram_rd;
        if (load_req) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign wr_en      = (state_q == LOAD) && host_valid;
  assign enter_load = (state_q != LOAD) && (state_d == LOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // CPU reset window down-counter, loaded on the edge that leaves LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      crst_cnt <= '0;
    end else if ((state_q == LOAD) && (state_d == CRST)) begin
      crst_cnt <= 2'(CRST_CYCLES - 1);
    end else if ((state_q == CRST) && (crst_cnt != '0)) begin
      crst_cnt <= crst_cnt - 2'd1;
    end
  end

  // Write count and checksum, restarted on every entry into LOAD.
  always_ff @(posedge clk) begin
    if (reset || enter_load) begin
      wr_count <= '0;
      checksum <= '0;
    end else if (wr_en) begin
      wr_count <= sat_inc(wr_count);
      checksum <= checksum + host_data;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl with hand-computed expectations.
module tb_prog_loader_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] host_addr;
  logic [7:0] host_data;
  logic       run_req;
  logic       load_req;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_n_reset;
  logic [1:0] state;
  logic [4:0] wr_count;
  logic [7:0] checksum;

  int tests = 0;
  int fails = 0;

  prog_loader_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .run_req     (run_req),
    .load_req    (load_req),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_n_reset (cpu_n_reset),
    .state       (state),
    .wr_count    (wr_count),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_data = '0;
    run_req = 1'b0; load_req = 1'b0; cpu_addr = '0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    chk("rst_checksum", 32'(checksum), 32'h0);
    chk("rst_cpu_n_reset", 32'(cpu_n_reset), 32'h0);
    reset = 1'b0;
    tick();
    chk("load_host_ready", 32'(host_ready), 32'h1);
    chk("load_cpu_data", 32'(cpu_data), 32'h0);

    // Two writes then run.
    host_valid = 1'b1; host_addr = 4'd0; host_data = 8'h31;
    tick();
    host_addr = 4'd1; host_data = 8'h0F;
    tick();
    host_valid = 1'b0;
    #1;
    chk("two_wr_count", 32'(wr_count), 32'd2);
    chk("two_checksum", 32'(checksum), 32'h40);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("crst1_state", 32'(state), 32'h1);
    chk("crst1_nrst", 32'(cpu_n_reset), 32'h0);
    chk("crst1_ready", 32'(host_ready), 32'h0);
    tick();
    chk("crst2_nrst", 32'(cpu_n_reset), 32'h0);
    tick();
    chk("run_state", 32'(state), 32'h2);
    chk("run_nrst", 32'(cpu_n_reset), 32'h1);
    cpu_addr = 4'd1; #1;
    chk("run_fetch1", 32'(cpu_data), 32'h0F);
    cpu_addr = 4'd0; #1;
    chk("run_fetch0", 32'(cpu_data), 32'h31);

    // Host stalled in RUN, then accepted after load_req.
    host_valid = 1'b1; host_addr = 4'd5; host_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ready", 32'(host_ready), 32'h0);
      chk("stall_wr_count", 32'(wr_count), 32'd2);
    end
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("reload_state", 32'(state), 32'h0);
    chk("reload_ready", 32'(host_ready), 32'h1);
    chk("reload_wr_count", 32'(wr_count), 32'd0);
    tick();
    host_valid = 1'b0;
    chk("pending_wr_count", 32'(wr_count), 32'd1);
    chk("pending_checksum", 32'(checksum), 32'h5A);

    // Abort from CRST.
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("abort_crst_state", 32'(state), 32'h1);
    chk("abort_crst_nrst", 32'(cpu_n_reset), 32'h0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("abort_state", 32'(state), 32'h0);
    chk("abort_nrst", 32'(cpu_n_reset), 32'h0);
    chk("abort_wr_count", 32'(wr_count), 32'd0);
    tick();
    chk("abort_hold_nrst", 32'(cpu_n_reset), 32'h0);
    chk("abort_hold_state", 32'(state), 32'h0);

    // Simultaneous write and run_req.
    host_valid = 1'b1; run_req = 1'b1; host_addr = 4'd0; host_data = 8'hB7;
    tick();
    host_valid = 1'b0; run_req = 1'b0;
    chk("simul_state", 32'(state), 32'h1);
    chk("simul_wr_count", 32'(wr_count), 32'd1);
    chk("simul_checksum", 32'(checksum), 32'hB7);
    tick(); tick();
    chk("simul_run_state", 32'(state), 32'h2);
    cpu_addr = 4'd0; #1;
    chk("simul_fetch0", 32'(cpu_data), 32'hB7);
    cpu_addr = 4'd5; #1;
    chk("simul_fetch5", 32'(cpu_data), 32'h5A);
    cpu_addr = 4'd1; #1;
    chk("simul_fetch1", 32'(cpu_data), 32'h0F);

    // load_req wins over run_req in RUN.
    load_req = 1'b1; run_req = 1'b1;
    tick();
    load_req = 1'b0; run_req = 1'b0;
    chk("prio_state", 32'(state), 32'h0);
    chk("prio_wr_count", 32'(wr_count), 32'd0);
    chk("prio_checksum", 32'(checksum), 32'h0);

    // Saturation: 20 writes of 8'h10.
    host_valid = 1'b1; host_data = 8'h10;
    for (int i = 0; i < 20; i++) begin
      host_addr = 4'(i);
      tick();
      chk("sat_wr_count", 32'(wr_count), (i + 1 > 16) ? 32'd16 : 32'(i + 1));
    end
    host_valid = 1'b0;
    chk("sat_checksum", 32'(checksum), 32'h40);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick(); tick();
    chk("sat_run_state", 32'(state), 32'h2);
    cpu_addr = 4'd7; #1;
    chk("sat_fetch7", 32'(cpu_data), 32'h10);
    cpu_addr = 4'd2; #1;
    chk("sat_fetch2", 32'(cpu_data), 32'h10);

    // Reset mid-RUN clears memory and returns to LOAD.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rrst_state", 32'(state), 32'h0);
    chk("rrst_nrst", 32'(cpu_n_reset), 32'h0);
    chk("rrst_wr_count", 32'(wr_count), 32'd0);
    chk("rrst_checksum", 32'(checksum), 32'h0);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick(); tick();
    chk("rrst_run_state", 32'(state), 32'h2);
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a); #1;
      chk("rrst_mem_clear", 32'(cpu_data), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
